neo_spike_detector: RTL and testbench

- Downstream stage of the moving-average filter: consumes its DATA_OUT/DATA_VALID stream and computes the Nonlinear Energy Operator per sample, psi[n] = x[n-1]^2 - x[n]*x[n-2].
- Compares psi against a runtime threshold and raises a one-cycle spike flag.
- Applies a sample-counted refractory period after each spike.
- Output feeds the spike-sorting/framing logic on the same system clock.

---
 rtl/neo_spike_detector.sv | 136 +++++++++++++
 tb/tb_neo_spike_detector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/neo_spike_detector.sv
// NEO spike detector: psi[n] = x[n-1]^2 - x[n]*x[n-2], threshold + refractory.
// Define SPIKE_CNT_EN to add the saturating SPIKE_CNT output.
module neo_spike_detector #(
  parameter int BITSIZE    = 12,
  parameter int REFRAC_LEN = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 START_FLAG,
  input  logic [BITSIZE-1:0]   DATA_IN,
  input  logic [2*BITSIZE-1:0] THRESHOLD,
  output logic [2*BITSIZE:0]   DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 SPIKE_FLAG,
`ifdef SPIKE_CNT_EN
  output logic [CNT_WIDTH-1:0] SPIKE_CNT,
`endif
  output logic                 BUSY
);

  localparam int MW = 2 * BITSIZE;
  localparam int PW = 2 * BITSIZE + 1;
  localparam int RW = (REFRAC_LEN < 1) ? 1 : $clog2(REFRAC_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_ARMED,
    S_REFRACT
  } state_t;

  state_t r_state, w_state_nxt;

  logic                     r_start_d;
  logic                     w_acc;
  logic [1:0]               r_fill;
  logic signed [BITSIZE-1:0] w_x;
  logic signed [BITSIZE-1:0] r_x0, r_x1, r_x2;
  logic signed [MW-1:0]     r_sq, r_cr;
  logic                     r_v1, r_v2;
  logic signed [PW-1:0]     w_psi, w_thr;
  logic                     w_hit;
  logic [RW-1:0]            r_rcnt, w_rcnt_nxt;
  logic                     w_spike;

  assign w_acc = START_FLAG & ~r_start_d & EN;
  assign w_x   = {~DATA_IN[BITSIZE-1], DATA_IN[BITSIZE-2:0]};
  assign w_psi = PW'(r_sq) - PW'(r_cr);
  assign w_thr = $signed({1'b0, THRESHOLD});
  assign w_hit = (w_psi > 0) && (w_psi > w_thr);
  assign BUSY  = (r_state == S_REFRACT);

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_spike     = 1'b0;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_WARMUP;
      S_WARMUP: begin
        if (w_acc && r_fill == 2'd2)
          w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (r_v2 && w_hit) begin
          w_spike = 1'b1;
          if (REFRAC_LEN > 0) begin
            w_state_nxt = S_REFRACT;
            w_rcnt_nxt  = RW'(REFRAC_LEN);
          end
        end
      end
      S_REFRACT: begin
        if (r_v2) begin
          w_rcnt_nxt = r_rcnt - RW'(1);
          if (r_rcnt == RW'(1))
            w_state_nxt = S_ARMED;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Disable clears everything except the edge detector history.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      r_start_d  <= START_FLAG & ~RST;
      r_state    <= S_IDLE;
      r_rcnt     <= '0;
      r_fill     <= '0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_sq       <= '0;
      r_cr       <= '0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      SPIKE_FLAG <= 1'b0;
    end else begin
      r_start_d <= START_FLAG;
      r_state   <= w_state_nxt;
      r_rcnt    <= w_rcnt_nxt;
      if (w_acc) begin
        r_x2 <= r_x1;
        r_x1 <= r_x0;
        r_x0 <= w_x;
        if (r_fill != 2'd2)
          r_fill <= r_fill + 2'd1;
      end
      r_v1       <= w_acc && (r_fill == 2'd2);
      r_sq       <= MW'(r_x1) * MW'(r_x1);
      r_cr       <= MW'(r_x0) * MW'(r_x2);
      r_v2       <= r_v1;
      DATA_VALID <= r_v2;
      if (r_v2)
        DATA_OUT <= w_psi;
      SPIKE_FLAG <= w_spike;
    end
  end

`ifdef SPIKE_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST)
      SPIKE_CNT <= '0;
    else if (EN && w_spike && !(&SPIKE_CNT))
      SPIKE_CNT <= SPIKE_CNT + CNT_WIDTH'(1);
  end
`else
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: tb/tb_neo_spike_detector.sv
// Directed table-driven bench for neo_spike_detector.
// Optional SPIKE_CNT_EN checks run with a 2-bit counter.
module tb_neo_spike_detector;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b1;
  logic        START_FLAG = 1'b0;
  logic [11:0] DATA_IN = '0;
  logic [23:0] THRESHOLD = '0;
  logic [24:0] DATA_OUT;
  logic        DATA_VALID;
  logic        SPIKE_FLAG;
  logic        BUSY;
`ifdef SPIKE_CNT_EN
  logic [1:0]  SPIKE_CNT;
  int          m_cnt = 0;
`endif

  neo_spike_detector #(
    .BITSIZE(12),
    .REFRAC_LEN(16),
`ifdef SPIKE_CNT_EN
    .CNT_WIDTH(2)
`else
    .CNT_WIDTH(16)
`endif
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .START_FLAG(START_FLAG),
    .DATA_IN(DATA_IN),
    .THRESHOLD(THRESHOLD),
    .DATA_OUT(DATA_OUT),
    .DATA_VALID(DATA_VALID),
    .SPIKE_FLAG(SPIKE_FLAG),
`ifdef SPIKE_CNT_EN
    .SPIKE_CNT(SPIKE_CNT),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic   pre_rst;
    int     din;
    int     thr;
    logic   v;
    longint psi;
    logic   sp;
    logic   bz;
  } vec_t;

  vec_t   tbl[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint last = 0;

  task automatic add(input logic pr, input int din, input int thr,
                     input logic v, input longint psi,
                     input logic sp, input logic bz);
    vec_t e;
    e.pre_rst = pr;
    e.din = din;
    e.thr = thr;
    e.v = v;
    e.psi = psi;
    e.sp = sp;
    e.bz = bz;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dout"}, $signed(DATA_OUT), 0);
    chk({nm, "_valid"}, DATA_VALID, 0);
    chk({nm, "_spike"}, SPIKE_FLAG, 0);
    chk({nm, "_busy"}, BUSY, 0);
  endtask

  task automatic do_reset();
    @(posedge CLK) #1;
    RST = 1'b1;
    @(posedge CLK) #1;
    RST = 1'b0;
    last = 0;
`ifdef SPIKE_CNT_EN
    m_cnt = 0;
    chk("rst_cnt", SPIKE_CNT, 0);
`endif
    chk_zero("rst");
  endtask

  task automatic apply(input vec_t e, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    if (e.pre_rst)
      do_reset();
    @(posedge CLK) #1;
    DATA_IN = 12'(e.din);
    THRESHOLD = 24'(e.thr);
    START_FLAG = 1'b1;
    @(posedge CLK) #1;
    START_FLAG = 1'b0;
    @(posedge CLK) #1;
    chk({s, "_early"}, DATA_VALID, 0);
    @(posedge CLK) #1;
    if (e.v)
      last = e.psi;
    chk({s, "_valid"}, DATA_VALID, e.v);
    chk({s, "_dout"}, $signed(DATA_OUT), last);
    chk({s, "_spike"}, SPIKE_FLAG, e.sp);
    chk({s, "_busy"}, BUSY, e.bz);
`ifdef SPIKE_CNT_EN
    if (e.sp && m_cnt < 3)
      m_cnt++;
    chk({s, "_cnt"}, SPIKE_CNT, m_cnt);
`endif
    @(posedge CLK) #1;
    chk({s, "_pulse"}, DATA_VALID, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Constant x=100: psi 0 from sample 3 onwards.
    add(1, 2148, 50000, 0, 0, 0, 0);
    add(0, 2148, 50000, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 2148, 50000, 1, 0, 0, 0);
    // Single spike then refractory suppression.
    add(1, 2048, 50000, 0, 0, 0, 0);
    add(0, 2048, 50000, 0, 0, 0, 0);
    add(0, 2348, 50000, 1, 0, 0, 0);
    add(0, 2048, 50000, 1, 90000, 1, 1);
    add(0, 2048, 50000, 1, 0, 0, 1);
    add(0, 2048, 50000, 1, 0, 0, 1);
    add(0, 2048, 50000, 1, 0, 0, 1);
    add(0, 2348, 50000, 1, 0, 0, 1);
    add(0, 2048, 50000, 1, 90000, 0, 1);
    add(0, 2048, 50000, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++)
      add(0, 2048, 50000, 1, 0, 0, 1);
    add(0, 2048, 50000, 1, 0, 0, 0);
    add(0, 2348, 50000, 1, 0, 0, 0);
    add(0, 2048, 50000, 1, 90000, 1, 1);
    // Negative psi, equality and just-above threshold.
    add(1, 2148, 50000, 0, 0, 0, 0);
    add(0, 2048, 50000, 0, 0, 0, 0);
    add(0, 2148, 50000, 1, -10000, 0, 0);
    add(0, 2048, 90000, 1, 10000, 0, 0);
    add(0, 2348, 90000, 1, -30000, 0, 0);
    add(0, 2048, 90000, 1, 90000, 0, 0);
    add(0, 2348, 0, 1, -90000, 0, 0);
    add(0, 2048, 89999, 1, 90000, 1, 1);

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_zero("init");

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i);

    // Reset while refractory.
    chk("refr_busy", BUSY, 1);
    do_reset();

    // Reset while the third sample is in the pipeline.
    tbl.delete();
    add(0, 2148, 50000, 0, 0, 0, 0);
    add(0, 2048, 50000, 0, 0, 0, 0);
    apply(tbl[0], 100);
    apply(tbl[1], 101);
    @(posedge CLK) #1;
    DATA_IN = 12'd2148;
    START_FLAG = 1'b1;
    @(posedge CLK) #1;
    START_FLAG = 1'b0;
    RST = 1'b1;
    @(posedge CLK) #1;
    RST = 1'b0;
    chk_zero("pipe_rst");
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK) #1;
      chk($sformatf("stale_valid%0d", k), DATA_VALID, 0);
    end
    tbl.delete();
    add(0, 2148, 50000, 0, 0, 0, 0);
    add(0, 2048, 50000, 0, 0, 0, 0);
    add(0, 2148, 50000, 1, -10000, 0, 0);
    for (int i = 0; i < 3; i++)
      apply(tbl[i], 200 + i);

    // Disable clears outputs; edges while disabled are ignored.
    @(posedge CLK) #1;
    EN = 1'b0;
    @(posedge CLK) #1;
    last = 0;
    chk_zero("dis");
    DATA_IN = 12'd2348;
    START_FLAG = 1'b1;
    @(posedge CLK) #1;
    START_FLAG = 1'b0;
    @(posedge CLK) #1;
    EN = 1'b1;
`ifdef SPIKE_CNT_EN
    chk("dis_cnt", SPIKE_CNT, m_cnt);
`endif
    for (int i = 0; i < 3; i++)
      apply(tbl[i], 300 + i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
